// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, sequencer states,
// reset PC default and the jump-condition helper.
package cpu_pkg;

  localparam int          INSTR_W      = 16;
  localparam int          PC_W_DEF     = 16;
  localparam logic [15:0] CPU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  function automatic logic take_jump(
    input logic jz,
    input logic z
  );
    return jz & z;
  endfunction

endpackage

// File: rtl/cpu_pc.sv
// Program counter: holds pc, advances by one (wrapping) or loads
// the jump target when i_adv is high. Ports: i_adv, i_jump, i_target, o_pc.
module cpu_pc
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_adv,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_nxt;

  // natural modulo-2^PC_W wrap of the adder
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_nxt = i_jump ? i_target : w_pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_adv) begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: IDLE -> FETCH (req/ack) -> EXEC.
// Ports: run/step start, imem_* fetch bus, ir to decoder, jmp_if_z/zero/
// jump_target for branch, exec_en strobe, pc, busy, retired count.
// Optional single-step start from IDLE when CPU_SEQ_STEP_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               jmp_if_z,
  input  logic               zero,
  input  logic [PC_W-1:0]    jump_target,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic [31:0]        retired
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic [31:0]        r_retired;
  logic               w_start;
  logic               w_load_ir;
  logic               w_jump;
  logic [PC_W-1:0]    w_pc;

`ifdef CPU_SEQ_STEP_EN
  // run and step both start from IDLE; the exit from EXEC only
  // looks at run, so a step alone retires exactly one instruction
  assign w_start = run | step;
`else
  assign w_start = run | (step & 1'b0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    exec_en     = 1'b0;
    busy        = 1'b1;
    w_load_ir   = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_load_ir   = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        exec_en     = 1'b1;
        w_state_nxt = run ? FETCH : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (w_load_ir) begin
      r_ir <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (exec_en) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign w_jump = take_jump(jmp_if_z, zero);

  cpu_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_adv    (exec_en),
    .i_jump   (w_jump),
    .i_target (jump_target),
    .o_pc     (w_pc)
  );

  assign pc        = w_pc;
  assign imem_addr = w_pc;
  assign ir        = r_ir;
  assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level model,
// per-cycle compare, and directed vectors with literal expectations.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] ir;
  logic        jmp_if_z = 1'b0;
  logic        zero = 1'b0;
  logic [15:0] jump_target = '0;
  logic        exec_en;
  logic [15:0] pc;
  logic        busy;
  logic [31:0] retired;

  int n_chk = 0;
  int n_err = 0;

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .jmp_if_z    (jmp_if_z),
    .zero        (zero),
    .jump_target (jump_target),
    .exec_en     (exec_en),
    .pc          (pc),
    .busy        (busy),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // memory configuration
  int  wait_addr = -1;
  int  wait_n    = 0;
  bit  wait_all  = 0;
  bit  force_ack = 0;
  int  wcnt      = 0;

  // model: phase 0 = idle, 1 = waiting for instruction, 2 = executing
  int          m_phase = 0;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_ir    = 16'h0000;
  logic [31:0] m_ret   = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_pc    = 16'h0000;
      m_ir    = 16'h0000;
      m_ret   = 32'd0;
    end else begin
      case (m_phase)
        0: begin
`ifdef CPU_SEQ_STEP_EN
          if (run || step) m_phase = 1;
`else
          if (run) m_phase = 1;
`endif
        end
        1: begin
          if (imem_ack) begin
            m_ir    = imem_rdata;
            m_phase = 2;
          end
        end
        default: begin
          if (jmp_if_z && zero) m_pc = jump_target;
          else m_pc = m_pc + 16'd1;
          m_ret   = m_ret + 32'd1;
          m_phase = run ? 1 : 0;
        end
      endcase
    end
  end

  // compare on the falling edge, then drive memory response
  always @(negedge clk) begin
    int need;
    if (rst_n) begin
      chk("req", imem_req, m_phase == 1);
      chk("exec_en", exec_en, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("retired", retired, m_ret);
      if (m_phase == 1) chk("addr", imem_addr, m_pc);
    end
    if (imem_req) begin
      need = (wait_all || int'(imem_addr) == wait_addr) ? wait_n : 0;
      if (wcnt >= need) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_data(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'h0BAD;
        wcnt       = wcnt + 1;
      end
    end else begin
      wcnt       = 0;
      imem_ack   = force_ack;
      imem_rdata = 16'hDEAD;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nexec;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ret", retired, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("idle_busy", busy, 0);

    // zero-wait back-to-back run
    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("t1_req", imem_req, k % 2);
      chk("t1_exec", exec_en, (k % 2) == 0);
      if (k % 2 == 1) chk("t1_addr", imem_addr, (k - 1) / 2);
    end
    tick;
    chk("t1_ret4", retired, 4);
    chk("t1_pc4", pc, 4);
    run = 1'b0;
    tick;
    chk("t1_lastexec", exec_en, 1);
    tick;
    chk("t1_idle", busy, 0);
    chk("t1_ret5", retired, 5);

    // three wait states on address 5, run dropped mid-fetch
    wait_addr = 5;
    wait_n    = 3;
    run       = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("t2_req", imem_req, 1);
      chk("t2_addr", imem_addr, 5);
      chk("t2_noexec", exec_en, 0);
      if (k == 2) run = 1'b0;
    end
    tick;
    chk("t2_exec", exec_en, 1);
    chk("t2_ir", ir, mem_data(16'd5));
    tick;
    chk("t2_once", exec_en, 0);
    chk("t2_idle_req", imem_req, 0);
    chk("t2_ret6", retired, 6);
    chk("t2_pc6", pc, 6);
    wait_addr = -1;

    // jumps and pc wrap
    jmp_if_z    = 1'b1;
    zero        = 1'b1;
    jump_target = 16'h0040;
    run         = 1'b1;
    tick; tick; tick;
    chk("t3_jmp", imem_addr, 16'h0040);
    zero = 1'b0;
    tick; tick;
    chk("t3_nojmp", imem_addr, 16'h0041);
    zero        = 1'b1;
    jump_target = 16'hFFFF;
    tick; tick;
    chk("t3_ffff", imem_addr, 16'hFFFF);
    jmp_if_z = 1'b0;
    tick; tick;
    chk("t3_wrap", imem_addr, 16'h0000);
    chk("t3_ret10", retired, 10);
    run = 1'b0;
    tick; tick;
    chk("t3_idle", busy, 0);
    chk("t3_pc1", pc, 16'h0001);

    // stray ack while idle must not touch ir
    force_ack = 1'b1;
    tick; tick; tick;
    chk("stray_ir", ir, mem_data(16'h0000));
    chk("stray_busy", busy, 0);
    force_ack = 1'b0;

    // single step
    step  = 1'b1;
    nexec = 0;
    tick;
    step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (exec_en) nexec++;
      tick;
    end
`ifdef CPU_SEQ_STEP_EN
    chk("step_execs", nexec, 1);
    chk("step_ret", retired, 12);
`else
    chk("step_execs", nexec, 0);
    chk("step_ret", retired, 11);
`endif
    chk("step_idle", busy, 0);

    // reset while a fetch is waiting
    wait_all = 1;
    wait_n   = 20;
    run      = 1'b1;
    tick; tick;
    chk("mid_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_ret", retired, 0);
    run      = 1'b0;
    wait_all = 0;
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. Fetches instructions from instruction memory over a req/ack handshake, holds them in an instruction register that feeds the instruction decoder, and issues a one-cycle execute strobe that gates the decoder's A/D/M load enables. It owns the program counter, resolving jump-if-zero against the ALU zero flag.

## Interface
Parameters:
- PC_W, 16, program counter / instruction address width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-running execution
- step  in  1  single-cycle pulse; executes exactly one instruction from IDLE (see Configuration)
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  fetched instruction
- ir  out  16  instruction register, drives decoder instr input
- jmp_if_z  in  1  from decoder, decoded from ir
- zero  in  1  ALU result zero flag
- jump_target  in  PC_W  A-register value, jump destination
- exec_en  out  1  execute strobe; datapath register loads are ANDed with it
- pc  out  PC_W  current program counter
- busy  out  1  1 when not in IDLE
- retired  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: imem_req=0, exec_en=0. To FETCH when run=1 (or step=1 when enabled); else stay.
- FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack=1: ir <= imem_rdata, go EXEC. Otherwise stay (unbounded wait states).
- EXEC: exec_en=1 for exactly this cycle. At cycle end: pc <= (jmp_if_z && zero) ? jump_target : pc+1; retired <= retired+1. Next state FETCH if run=1, else IDLE.
- run falling during FETCH or EXEC: current instruction completes (fetch waits for ack, EXEC retires), then IDLE. No instruction is abandoned by run.
- imem_ack outside FETCH: ignored; ir unchanged.
- pc+1 wraps modulo 2^PC_W (all-ones -> 0). retired wraps 2^32-1 -> 0.
- jump_target truncated/used at PC_W bits; zero and jmp_if_z sampled only in EXEC.

## Timing
- Reset (async assert): state=IDLE, pc=RESET_PC, ir=0, retired=0, imem_req=0, exec_en=0, busy=0. Outputs are registered or decoded from state, so they drop immediately on rst_n assertion; reset mid-fetch aborts the request with no completion.
- Reset release: first fetch request earliest on the cycle after run is seen high in IDLE.
- Zero-wait memory (ack in first FETCH cycle): 2 cycles per instruction, back-to-back under run=1.
- Each wait cycle adds one cycle; exec_en never asserts before ir is loaded.
- ir valid from the cycle after ack; decoder and ALU are combinational from ir and must settle within the EXEC cycle.
- pc and retired update on the EXEC-to-next edge; new imem_addr visible in the following FETCH.

## Configuration
- CPU_SEQ_STEP_EN defined: step pulse in IDLE (run=0) starts one FETCH/EXEC and returns to IDLE; step outside IDLE ignored; run takes priority if both high.
- Undefined: step input ignored entirely; only run starts execution. Port remains present.

## Structure
- Shared package cpu_pkg: INSTR_W=16, state enum (IDLE, FETCH, EXEC), RESET_PC default.
- One sub-module natural: cpu_pc (PC register with increment/load-target mux, wrap behaviour); FSM, ir and retired counter stay in cpu_sequencer.

## Test plan
- Reset, run=1, zero-wait memory with instrs at 0..3 -> imem_addr 0,1,2,3 on alternate cycles; exec_en pulses every 2nd cycle; retired=4 after 8 cycles.
- ack delayed 3 cycles on address 5 -> imem_req and imem_addr=5 held 4 cycles; exec_en single pulse after ack; ir=imem_rdata from ack cycle.
- EXEC with jmp_if_z=1, zero=1, jump_target=0x0040 -> next imem_addr=0x0040; same with zero=0 -> pc+1.
- pc=0xFFFF, non-jump instruction -> next pc=0x0000, retired increments.
- run dropped mid-FETCH -> instruction completes, exec_en pulses once, then IDLE with imem_req=0; rst_n asserted mid-FETCH -> imem_req=0 same cycle, pc=RESET_PC.
- CPU_SEQ_STEP_EN defined, run=0, step pulse -> exactly one exec_en, retired+1, back to IDLE; undefined -> no activity.
